// File: rtl/en_dff_pkg.sv
// Shared constants for the enable-capable register slice (en_dff_reg and its bit cell).
package en_dff_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned MAX_WIDTH     = 64;

    localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VAL = '0;

endpackage

// File: rtl/D_FF.sv
// Existing positive-edge D flip-flop with asynchronous active-high reset to 0.
module D_FF (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/en_dff_bit.sv
// One register bit: enable mux (plus clear mux when ENREG_CLR_EN is defined) feeding a D_FF.
module en_dff_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic en,
`ifdef ENREG_CLR_EN
    input  logic clr,
`endif
    output logic q
);

    logic en_sel;
    logic nxt;
    logic ff_d;
    logic ff_q;

    mux2_1 u_en_mux (
        .i0  (q),
        .i1  (d),
        .sel (en),
        .y   (en_sel)
    );

`ifdef ENREG_CLR_EN
    mux2_1 u_clr_mux (
        .i0  (en_sel),
        .i1  (RESET_BIT),
        .sel (clr),
        .y   (nxt)
    );
`else
    always_comb begin
        nxt = en_sel;
    end
`endif

    // D_FF resets to 0; storing the bit XOR RESET_BIT makes reset yield RESET_BIT at q.
    always_comb begin
        ff_d = nxt ^ RESET_BIT;
        q    = ff_q ^ RESET_BIT;
    end

    D_FF u_ff (
        .clk   (clk),
        .reset (reset),
        .d     (ff_d),
        .q     (ff_q)
    );

endmodule

// File: rtl/mux2_1.sv
// Existing 2:1 select primitive: y = sel ? i1 : i0.
module mux2_1 (
    input  logic i0,
    input  logic i1,
    input  logic sel,
    output logic y
);

    always_comb begin
        y = sel ? i1 : i0;
    end

endmodule

// File: rtl/en_dff_reg.sv
// WIDTH-bit register with load enable built from en_dff_bit cells.
// Optional synchronous clear input clr when ENREG_CLR_EN is defined.
module en_dff_reg
    import en_dff_pkg::*;
#(
    parameter int unsigned          WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
`ifdef ENREG_CLR_EN
    input  logic             clr,
`endif
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        en_dff_bit #(
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .d     (d[i]),
            .en    (en),
`ifdef ENREG_CLR_EN
            .clr   (clr),
`endif
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_en_dff_reg.sv
// Scoreboard bench for en_dff_reg: a 1-bit default instance and an 8-bit instance with RESET_VAL 8'h5A.
module tb_en_dff_reg;

    logic       clk;
    logic       reset;
    logic [7:0] d;
    logic       en;
    logic       q1;
    logic [7:0] q8;
`ifdef ENREG_CLR_EN
    logic       clr;
`endif

    typedef struct {
        int         id;
        logic       exp1;
        logic [7:0] exp8;
    } sb_t;

    sb_t  sb[$];
    event chk_ev;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    en_dff_reg dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d[0:0]),
        .en    (en),
`ifdef ENREG_CLR_EN
        .clr   (clr),
`endif
        .q     (q1)
    );

    en_dff_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h5A)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .en    (en),
`ifdef ENREG_CLR_EN
        .clr   (clr),
`endif
        .q     (q8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d entries pending", sb.size());
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expected entry after each falling edge, or on an explicit mid-cycle check.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (q1 !== e.exp1) begin
                    n_fail++;
                    $display("FAIL q1 step %0d: got %b expected %b", e.id, q1, e.exp1);
                end
                n_cmp++;
                if (q8 !== e.exp8) begin
                    n_fail++;
                    $display("FAIL q8 step %0d: got %h expected %h", e.id, q8, e.exp8);
                end
            end
        end
    end

    task automatic push(input logic e1, input logic [7:0] e8);
        sb_t e;
        step_id++;
        e.id   = step_id;
        e.exp1 = e1;
        e.exp8 = e8;
        sb.push_back(e);
    endtask

    // Drive inputs shortly after a falling edge; expected value is q after the next rising edge.
    task automatic step(input logic [7:0] dv, input logic env, input logic e1, input logic [7:0] e8);
        @(negedge clk);
        #1;
        reset = 1'b0;
        d     = dv;
        en    = env;
        push(e1, e8);
    endtask

    logic [7:0] tog [6];
    logic [7:0] fol [6];
    logic       fol1 [6];

    initial begin
        tog = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        fol = '{8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h3C, 8'hA5};
        fol1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        d     = 8'h00;
        en    = 1'b0;
`ifdef ENREG_CLR_EN
        clr   = 1'b0;
`endif
        // Reset value visible immediately, before any clock edge.
        #2;
        push(1'b0, 8'h5A);
        ->chk_ev;

        // Reset released, en=0: reset value held.
        for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0, 8'h5A);
        // Disabled: d ignored.
        for (int i = 0; i < 6; i++) step(8'hFF, 1'b0, 1'b0, 8'h5A);
        // Enabled zero.
        for (int i = 0; i < 6; i++) step(8'h00, 1'b1, 1'b0, 8'h00);
        // Load ones and keep loading.
        for (int i = 0; i < 6; i++) step(8'hFF, 1'b1, 1'b1, 8'hFF);
        // Hold ones while d toggles.
        for (int i = 0; i < 6; i++) step(tog[i], 1'b0, 1'b1, 8'hFF);
        // Follow mode: q tracks d one edge later.
        for (int i = 0; i < 6; i++) step(fol[i], 1'b1, fol1[i], fol[i]);
        step(8'hFF, 1'b1, 1'b1, 8'hFF);

        // Asynchronous reset pulse between edges.
        @(negedge clk);
        #1;
        d     = 8'hFF;
        en    = 1'b0;
        reset = 1'b1;
        #1;
        push(1'b0, 8'h5A);
        ->chk_ev;
        #1;
        reset = 1'b0;
        push(1'b0, 8'h5A);

        step(8'h3C, 1'b1, 1'b0, 8'h3C);
`ifdef ENREG_CLR_EN
        @(negedge clk);
        #1;
        d   = 8'h3C;
        en  = 1'b1;
        clr = 1'b1;
        push(1'b0, 8'h5A);
        @(negedge clk);
        #1;
        clr = 1'b0;
        en  = 1'b0;
        push(1'b0, 8'h5A);
`else
        step(8'hC3, 1'b0, 1'b0, 8'h3C);
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
